// File: rtl/core_pkg.sv
// core_pkg: shared data width, access size and LSU state encodings
package core_pkg;
    localparam int DATA_WIDTH = 32;
    typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} mem_size_t;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_axil_master_if.sv
// lsu_axil_master_if: word-addressed AXI-lite channels without write strobes or B channel
interface lsu_axil_master_if
    import core_pkg::*;
();
    logic [31:0] araddr;
    logic arvalid, arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic rvalid, rready;
    logic [31:0] awaddr;
    logic awvalid, awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic wvalid, wready;
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid,
        input  arready, rdata, rvalid, awready, wready
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid,
        output arready, rdata, rvalid, awready, wready
    );
endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: sub-word load extraction/extension and read-modify-write store merge
module lsu_data_align
    import core_pkg::*;
(
    input  mem_size_t             size,
    input  logic                  uns,
    input  logic [1:0]            lane,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);
    logic [7:0] b;
    logic [15:0] h;
    logic [DATA_WIDTH-1:0] mask, wrep;
    // select the addressed lane, extend it, and splice store data into the read word
    always_comb begin
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        load_data = size == SIZE_B ? {{(DATA_WIDTH-8){b[7] & ~uns}}, b} :
                    size == SIZE_H ? {{(DATA_WIDTH-16){h[15] & ~uns}}, h} : rdata;
        mask = size == SIZE_B ? DATA_WIDTH'(8'hFF) << {lane, 3'b000} :
               size == SIZE_H ? DATA_WIDTH'(16'hFFFF) << {lane[1], 4'b0000} : {DATA_WIDTH{1'b1}};
        wrep = size == SIZE_B ? {(DATA_WIDTH/8){wdata[7:0]}} :
               size == SIZE_H ? {(DATA_WIDTH/16){wdata[15:0]}} : wdata;
        store_data = (rdata & ~mask) | (wrep & mask);
    end
endmodule

// File: rtl/lsu_axil_master.sv
// lsu_axil_master: one-at-a-time load/store bridge onto word-only AXI-lite RAM; LSU_MISALIGN_TRAP_EN enables misalignment traps
module lsu_axil_master
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  mem_size_t             req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    lsu_axil_master_if.master     axi
);
    lsu_state_t state;
    logic we_q, uns_q, misalign;
    mem_size_t size_q;
    logic [1:0] lane_q;
    logic [DATA_WIDTH-1:0] wdata_q, load_data, store_data;

    assign req_ready = state == IDLE && !rst;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (req_size == SIZE_H && req_addr[0]) || (req_size == SIZE_W && req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    lsu_data_align u_align (
        .size(size_q), .uns(uns_q), .lane(lane_q), .rdata(axi.rdata), .wdata(wdata_q),
        .load_data(load_data), .store_data(store_data)
    );

    // request latch, FSM and AXI handshake bookkeeping; each valid drops on its own handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            we_q <= 1'b0;
            uns_q <= 1'b0;
            size_q <= SIZE_B;
            lane_q <= 2'b00;
            wdata_q <= '0;
            axi.araddr <= '0;
            axi.awaddr <= '0;
            axi.wdata <= '0;
            axi.arvalid <= 1'b0;
            axi.rready <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.wvalid <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q <= req_we;
                    uns_q <= req_unsigned;
                    size_q <= req_size;
                    lane_q <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    axi.araddr <= {2'b00, req_addr[31:2]};
                    axi.awaddr <= {2'b00, req_addr[31:2]};
                    if (misalign) begin
                        resp_valid <= 1'b1;
                        resp_err <= 1'b1;
                        resp_rdata <= '0;
                        state <= RESP;
                    end else if (req_we && req_size == SIZE_W) begin
                        axi.wdata <= req_wdata;
                        axi.awvalid <= 1'b1;
                        axi.wvalid <= 1'b1;
                        state <= WR;
                    end else begin
                        axi.arvalid <= 1'b1;
                        state <= RD_ADDR;
                    end
                end
                RD_ADDR: if (axi.arready) begin
                    axi.arvalid <= 1'b0;
                    axi.rready <= 1'b1;
                    state <= RD_DATA;
                end
                RD_DATA: if (axi.rvalid) begin
                    axi.rready <= 1'b0;
                    if (we_q) begin
                        axi.wdata <= store_data;
                        axi.awvalid <= 1'b1;
                        axi.wvalid <= 1'b1;
                        state <= WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                WR: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready) axi.wvalid <= 1'b0;
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        resp_rdata <= '0;
                        resp_valid <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err <= 1'b0;
                    resp_rdata <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axil_master.sv
// tb_lsu_axil_master: randomized and directed checks of lsu_axil_master against a transaction-level RAM model
module tb_lsu_axil_master;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    mem_size_t req_size = SIZE_W;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    lsu_axil_master_if axi ();

    lsu_axil_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    function automatic logic [31:0] ld(input logic [31:0] w, input logic [1:0] sz, input logic u, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!u) v = (v ^ 32'h80) - 32'h80;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
            if (!u) v = (v ^ 32'h8000) - 32'h8000;
        end else v = w;
        return v;
    endfunction

    function automatic logic [31:0] st(input logic [31:0] old, input logic [31:0] d, input logic [1:0] sz, input logic [31:0] a);
        int sh;
        logic [31:0] m;
        if (sz == 2'd2) return d;
        sh = sz == 2'd0 ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
        m = (sz == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~m) | ((d << sh) & m);
    endfunction

    function automatic logic mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
        return 1'b0 & sz[0] & a[0];
`endif
    endfunction

    logic stall = 1'b0, r_block = 1'b0;
    int aw_hold = 0, writes = 0;
    logic rd_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
    logic [3:0] aw_a;
    logic [31:0] w_d;
    logic busy = 1'b0, due = 1'b0, m_store, m_read, m_err, rd_done, aw_ok, w_ok;
    logic [3:0] m_idx;
    logic [31:0] m_w, m_rd;
    int m_ar, m_wr0, wv_cyc = 0, awv_cyc = 0;

    // slave RAM plus per-cycle comparison against the transaction model
    always @(negedge clk) begin : slave_and_check
        logic ar_hs, r_hs, aw_hs, w_hs;
        axi.arready = !stall || $urandom_range(2) != 0;
        axi.awready = aw_hold == 0 && (!stall || $urandom_range(2) != 0);
        axi.wready = !stall || $urandom_range(2) != 0;
        axi.rvalid = rd_pend && !r_block && (!stall || $urandom_range(2) != 0);
        axi.rdata = mem[axi.araddr[3:0]];
        if (rst) begin
            rd_pend = 1'b0;
            aw_got = 1'b0;
            w_got = 1'b0;
            busy = 1'b0;
            due = 1'b0;
        end else begin
            if (axi.awvalid && aw_hold > 0) aw_hold--;
            ar_hs = axi.arvalid && axi.arready;
            r_hs = axi.rvalid && axi.rready;
            aw_hs = axi.awvalid && axi.awready;
            w_hs = axi.wvalid && axi.wready;
            if (ar_hs) rd_pend = 1'b1;
            if (r_hs) rd_pend = 1'b0;
            if (aw_hs) begin aw_got = 1'b1; aw_a = axi.awaddr[3:0]; end
            if (w_hs) begin w_got = 1'b1; w_d = axi.wdata; end
            if (aw_got && w_got) begin
                mem[aw_a] = w_d;
                writes++;
                aw_got = 1'b0;
                w_got = 1'b0;
            end
            chk("req_ready", req_ready, !busy);
            if (axi.wvalid) wv_cyc++;
            if (axi.awvalid) awv_cyc++;
            if (!busy) chk("bus idle", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid}, 0);
            if (busy && (axi.arvalid || axi.rready)) begin
                chk("araddr", axi.araddr, {28'd0, m_idx});
                chk("read allowed", m_read, 1);
            end
            if (busy && (axi.awvalid || axi.wvalid)) begin
                chk("awaddr", axi.awaddr, {28'd0, m_idx});
                chk("wdata", axi.wdata, m_w);
                chk("write allowed", m_store && (!m_read || rd_done), 1);
            end
            if (due) begin
                chk("resp_valid", resp_valid, 1);
                chk("resp_rdata", resp_rdata, m_rd);
                chk("resp_err", resp_err, m_err);
                chk("ar count", m_ar, m_read);
                chk("write count", writes - m_wr0, m_store);
                if (m_store) begin
                    ref_mem[m_idx] = m_w;
                    chk("ram word", mem[m_idx], ref_mem[m_idx]);
                end
                busy = 1'b0;
                due = 1'b0;
            end else begin
                chk("resp_valid quiet", resp_valid, 0);
                if (busy) begin
                    if (ar_hs) m_ar++;
                    if (r_hs) begin rd_done = 1'b1; if (!m_store) due = 1'b1; end
                    if (aw_hs) aw_ok = 1'b1;
                    if (w_hs) w_ok = 1'b1;
                    if (m_store && aw_ok && w_ok) due = 1'b1;
                end
            end
            if (req_valid && req_ready) begin
                m_err = mis(req_size, req_addr);
                m_idx = req_addr[5:2];
                m_store = req_we && !m_err;
                m_read = !m_err && (!req_we || req_size != SIZE_W);
                m_rd = (req_we || m_err) ? 32'd0 : ld(ref_mem[m_idx], req_size, req_unsigned, req_addr);
                m_w = st(ref_mem[m_idx], req_wdata, req_size, req_addr);
                busy = 1'b1;
                due = m_err;
                rd_done = 1'b0;
                aw_ok = 1'b0;
                w_ok = 1'b0;
                m_ar = 0;
                m_wr0 = writes;
                wv_cyc = 0;
                awv_cyc = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er, output logic ar1,
                          output logic [31:0] wd, output logic [31:0] wa);
        int acc, n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we = we;
        req_size = mem_size_t'(sz);
        req_unsigned = u;
        req_addr = a;
        req_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 100);
        if (!req_ready) fail("accept timeout");
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = -1; rd = '0; er = 1'b0; ar1 = 1'b0; wd = '0; wa = '0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (cyc == acc + 1) ar1 = axi.arvalid;
            if (axi.wvalid) begin wd = axi.wdata; wa = axi.awaddr; end
            if (resp_valid) begin
                lat = cyc - acc;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
        end
        if (lat < 0) fail("resp timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, w0;
        logic [31:0] rd, wd, wa, old;
        logic er, ar1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", req_ready, 0);
        chk("rst resp", {resp_valid, resp_err}, 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid}, 0);
        chk("rst araddr", axi.araddr, 0);
        chk("rst awaddr", axi.awaddr, 0);
        chk("rst wdata", axi.wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_req(1, 2, 0, 32'h08, 32'hDEADBEEF, lat, rd, er, ar1, wd, wa);
        chk("sw lat", lat, 2); chk("sw awaddr", wa, 2); chk("sw wdata", wd, 32'hDEADBEEF); chk("sw no ar", ar1, 0);
        do_req(0, 2, 0, 32'h08, 0, lat, rd, er, ar1, wd, wa);
        chk("lw lat", lat, 3); chk("lw data", rd, 32'hDEADBEEF); chk("lw ar", ar1, 1);
        do_req(1, 0, 0, 32'h09, 32'h55, lat, rd, er, ar1, wd, wa);
        chk("sb ar", ar1, 1); chk("sb lat", lat, 4); chk("sb wdata", wd, 32'hDEAD55EF);
        do_req(0, 0, 0, 32'h0B, 0, lat, rd, er, ar1, wd, wa);
        chk("lb signed", rd, 32'hFFFFFFDE);
        do_req(0, 0, 1, 32'h0B, 0, lat, rd, er, ar1, wd, wa);
        chk("lbu", rd, 32'h000000DE);
        do_req(1, 1, 0, 32'h0A, 32'h8001, lat, rd, er, ar1, wd, wa);
        chk("sh lat", lat, 4); chk("sh wdata", wd, 32'h800155EF);
        do_req(0, 1, 0, 32'h0A, 0, lat, rd, er, ar1, wd, wa);
        chk("lh signed", rd, 32'hFFFF8001);
        do_req(0, 1, 1, 32'h0A, 0, lat, rd, er, ar1, wd, wa);
        chk("lhu", rd, 32'h00008001);

        w0 = writes;
        aw_hold = 3;
        do_req(1, 2, 0, 32'h10, 32'h12345678, lat, rd, er, ar1, wd, wa);
        @(posedge clk);
        chk("aw stall lat", lat, 5); chk("wvalid cycles", wv_cyc, 1); chk("awvalid cycles", awv_cyc, 4);
        chk("aw stall writes", writes - w0, 1);

        do_req(1, 2, 0, 32'h04, 32'hA5A51234, lat, rd, er, ar1, wd, wa);
        do_req(0, 2, 0, 32'h06, 0, lat, rd, er, ar1, wd, wa);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis lat", lat, 1); chk("mis err", er, 1); chk("mis rdata", rd, 0); chk("mis no ar", ar1, 0);
`else
        chk("mis lat", lat, 3); chk("mis err", er, 0); chk("mis rdata", rd, 32'hA5A51234);
`endif

        old = mem[4];
        r_block = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SIZE_B; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h77;
        @(negedge clk);
        if (!req_ready) fail("rst test accept");
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.rready && n < 50);
        if (!axi.rready) fail("rst test read phase");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid}, 0);
        chk("abort resp", resp_valid, 0);
        chk("abort idle", req_ready, 1);
        r_block = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort ram", mem[4], old);

        for (int i = 0; i < 400; i++) begin
            stall = $urandom_range(1) == 1;
            do_req($urandom_range(1) == 1, 2'($urandom_range(2)), $urandom_range(1) == 1,
                   32'($urandom_range(63)), $urandom, lat, rd, er, ar1, wd, wa);
        end
        stall = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
